lab2_proc_fetch_buf: RTL and testbench

LAB2_PROC_FETCH_BUF -- requirements
Module: lab2_proc_fetch_buf

---
 rtl/lab2_proc_fetch_buf.sv | 111 +++++++++++
 tb/tb_lab2_proc_fetch_buf.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_fetch_buf.sv
// Fetch-to-decode instruction buffer. Tracks in-flight imem requests so that
// responses belonging to a squashed fetch path are discarded on arrival.
module lab2_proc_fetch_buf #(
  parameter int p_entries = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_fire,
  output logic        req_allow,
  input  logic        enq_val,
  output logic        enq_rdy,
  input  logic [31:0] enq_inst,
  input  logic [31:0] enq_pc,
  input  logic        squash,
  output logic        deq_val,
  input  logic        deq_rdy,
  output logic [31:0] deq_inst,
  output logic [31:0] deq_pc,
  output logic [2:0]  deq_imm_type
);

  localparam int PW = $clog2(p_entries);
  localparam int CW = $clog2(p_entries + 1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [p_entries-1:0][31:0] inst_q, inst_d;
  logic [p_entries-1:0][31:0] pc_q, pc_d;
  logic [p_entries-1:0][2:0]  imm_q, imm_d;

  logic enq_acc, wr_fire, deq_fire;

  function automatic logic [2:0] imm_type_of(input logic [6:0] opc);
    case (opc)
      7'b0010011, 7'b0000011, 7'b1100111: imm_type_of = 3'd0;
      7'b0100011:                         imm_type_of = 3'd1;
      7'b1100011:                         imm_type_of = 3'd2;
      7'b0110111, 7'b0010111:             imm_type_of = 3'd3;
      7'b1101111:                         imm_type_of = 3'd4;
      default:                            imm_type_of = 3'd7;
    endcase
  endfunction

  assign req_allow    = (int'(outstanding_q) + int'(count_q)) < p_entries;
  assign enq_rdy      = (drop_cnt_q != '0) || (int'(count_q) < p_entries);
  assign deq_val      = (count_q != '0) && !squash;
  assign deq_inst     = inst_q[rd_ptr_q];
  assign deq_pc       = pc_q[rd_ptr_q];
  assign deq_imm_type = imm_q[rd_ptr_q];

  // A response with nothing outstanding is a protocol error and is ignored.
  assign enq_acc  = enq_val && enq_rdy && (outstanding_q != '0);
  assign wr_fire  = enq_acc && (drop_cnt_q == '0) && !squash;
  assign deq_fire = deq_val && deq_rdy;

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(enq_acc);
    inst_d        = inst_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    if (squash) begin
      // Everything still in flight belongs to the old path, except a request
      // fired this cycle, which is the redirected fetch.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = outstanding_q - CW'(enq_acc);
    end else begin
      if (enq_acc && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (wr_fire)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_fire) - CW'(deq_fire);
    end
    if (wr_fire) begin
      inst_d[wr_ptr_q] = enq_inst;
      pc_d[wr_ptr_q]   = enq_pc;
      imm_d[wr_ptr_q]  = imm_type_of(enq_inst[6:0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Payload storage carries no reset; valid state lives in count_q.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
    imm_q  <= imm_d;
  end

endmodule

// File: tb/tb_lab2_proc_fetch_buf.sv
// Directed bench for lab2_proc_fetch_buf: a depth-2 and a depth-4 instance
// share clock and reset but are driven independently.
module tb_lab2_proc_fetch_buf;

  logic clk, reset_n;
  int tests, fails;

  logic        p2_req_fire, p2_enq_val, p2_squash, p2_deq_rdy;
  logic [31:0] p2_enq_inst, p2_enq_pc;
  logic        p2_req_allow, p2_enq_rdy, p2_deq_val;
  logic [31:0] p2_deq_inst, p2_deq_pc;
  logic [2:0]  p2_deq_imm_type;

  logic        req_fire, enq_val, squash, deq_rdy;
  logic [31:0] enq_inst, enq_pc;
  logic        req_allow, enq_rdy, deq_val;
  logic [31:0] deq_inst, deq_pc;
  logic [2:0]  deq_imm_type;

  lab2_proc_fetch_buf #(.p_entries(2)) u_p2 (
    .clk(clk), .reset_n(reset_n), .req_fire(p2_req_fire), .req_allow(p2_req_allow),
    .enq_val(p2_enq_val), .enq_rdy(p2_enq_rdy), .enq_inst(p2_enq_inst), .enq_pc(p2_enq_pc),
    .squash(p2_squash), .deq_val(p2_deq_val), .deq_rdy(p2_deq_rdy), .deq_inst(p2_deq_inst),
    .deq_pc(p2_deq_pc), .deq_imm_type(p2_deq_imm_type)
  );

  lab2_proc_fetch_buf #(.p_entries(4)) u_p4 (
    .clk(clk), .reset_n(reset_n), .req_fire(req_fire), .req_allow(req_allow),
    .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_inst(enq_inst), .enq_pc(enq_pc),
    .squash(squash), .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .deq_imm_type(deq_imm_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p2_req_fire = 0; p2_enq_val = 0; p2_squash = 0; p2_deq_rdy = 0;
    p2_enq_inst = '0; p2_enq_pc = '0;
    req_fire = 0; enq_val = 0; squash = 0; deq_rdy = 0;
    enq_inst = '0; enq_pc = '0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    #2;
    tests++; if (p2_deq_val !== 1'b0) begin fails++; $display("FAIL reset_p2_deq_val: got %b exp 0", p2_deq_val); end
    tests++; if (p2_enq_rdy !== 1'b1) begin fails++; $display("FAIL reset_p2_enq_rdy: got %b exp 1", p2_enq_rdy); end
    tests++; if (p2_req_allow !== 1'b1) begin fails++; $display("FAIL reset_p2_req_allow: got %b exp 1", p2_req_allow); end
    tests++; if (deq_val !== 1'b0) begin fails++; $display("FAIL reset_p4_deq_val: got %b exp 0", deq_val); end
    tests++; if (req_allow !== 1'b1) begin fails++; $display("FAIL reset_p4_req_allow: got %b exp 1", req_allow); end
    tick(); tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_basic();
    p2_req_fire = 1;
    tick();
    p2_req_fire = 0; p2_enq_val = 1; p2_enq_inst = 32'h0050_0093; p2_enq_pc = 32'h200;
    #1;
    tests++; if (p2_deq_val !== 1'b0) begin fails++; $display("FAIL basic_no_bypass: got %b exp 0", p2_deq_val); end
    tick();
    p2_enq_val = 0;
    #1;
    tests++; if (p2_deq_val !== 1'b1) begin fails++; $display("FAIL basic_deq_val: got %b exp 1", p2_deq_val); end
    tests++; if (p2_deq_inst !== 32'h0050_0093) begin fails++; $display("FAIL basic_inst: got %h exp 00500093", p2_deq_inst); end
    tests++; if (p2_deq_pc !== 32'h200) begin fails++; $display("FAIL basic_pc: got %h exp 00000200", p2_deq_pc); end
    tests++; if (p2_deq_imm_type !== 3'd0) begin fails++; $display("FAIL basic_imm: got %0d exp 0", p2_deq_imm_type); end
    p2_deq_rdy = 1;
    tick();
    p2_deq_rdy = 0;
    #1;
    tests++; if (p2_deq_val !== 1'b0) begin fails++; $display("FAIL basic_drain: got %b exp 0", p2_deq_val); end
  endtask

  task automatic test_backpressure();
    p2_req_fire = 1;
    tick();
    p2_enq_val = 1; p2_enq_inst = 32'h0011_2023; p2_enq_pc = 32'h300;
    tick();
    p2_req_fire = 0; p2_enq_inst = 32'h0020_8463; p2_enq_pc = 32'h304;
    tick();
    p2_enq_val = 0;
    #1;
    tests++; if (u_p2.count_q !== 2'd2) begin fails++; $display("FAIL full_count: got %0d exp 2", u_p2.count_q); end
    tests++; if (p2_req_allow !== 1'b0) begin fails++; $display("FAIL full_req_allow: got %b exp 0", p2_req_allow); end
    tests++; if (p2_enq_rdy !== 1'b0) begin fails++; $display("FAIL full_enq_rdy: got %b exp 0", p2_enq_rdy); end
    tests++; if (p2_deq_imm_type !== 3'd1 || p2_deq_pc !== 32'h300) begin
      fails++; $display("FAIL full_head_S: got imm %0d pc %h exp imm 1 pc 00000300", p2_deq_imm_type, p2_deq_pc); end
    p2_deq_rdy = 1;
    tick();
    tests++; if (p2_deq_imm_type !== 3'd2 || p2_deq_pc !== 32'h304 || p2_deq_val !== 1'b1) begin
      fails++; $display("FAIL full_head_B: got val %b imm %0d pc %h exp val 1 imm 2 pc 00000304", p2_deq_val, p2_deq_imm_type, p2_deq_pc); end
    tick();
    p2_deq_rdy = 0;
    #1;
    tests++; if (p2_deq_val !== 1'b0) begin fails++; $display("FAIL full_drain: got %b exp 0", p2_deq_val); end
  endtask

  task automatic test_squash_inflight();
    req_fire = 1;
    tick();
    enq_val = 1; enq_inst = 32'h0000_0013; enq_pc = 32'h380;
    tick();
    enq_val = 0;
    tick();
    req_fire = 0; squash = 1; deq_rdy = 1;
    #1;
    tests++; if (deq_val !== 1'b0) begin fails++; $display("FAIL squash_deq_val: got %b exp 0", deq_val); end
    tick();
    squash = 0; deq_rdy = 0;
    enq_val = 1; enq_inst = 32'h0000_0033; enq_pc = 32'h500;
    #1;
    tests++; if (u_p4.drop_cnt_q !== 3'd2) begin fails++; $display("FAIL squash_drop_cnt: got %0d exp 2", u_p4.drop_cnt_q); end
    tick();
    tests++; if (deq_val !== 1'b0) begin fails++; $display("FAIL squash_drop1: got %b exp 0", deq_val); end
    enq_pc = 32'h504;
    tick();
    tests++; if (deq_val !== 1'b0 || u_p4.drop_cnt_q !== 3'd0) begin
      fails++; $display("FAIL squash_drop2: got val %b drop %0d exp val 0 drop 0", deq_val, u_p4.drop_cnt_q); end
    enq_val = 0; req_fire = 1;
    tick();
    req_fire = 0; enq_val = 1; enq_inst = 32'h0000_006F; enq_pc = 32'h400;
    tick();
    enq_val = 0;
    #1;
    tests++; if (deq_val !== 1'b1 || deq_inst !== 32'h6F || deq_pc !== 32'h400 || deq_imm_type !== 3'd4) begin
      fails++; $display("FAIL squash_third: got val %b inst %h pc %h imm %0d exp 1 0000006f 00000400 4", deq_val, deq_inst, deq_pc, deq_imm_type); end
    deq_rdy = 1;
    tick();
    deq_rdy = 0;
  endtask

  task automatic test_simultaneous();
    req_fire = 1;
    tick(); tick();
    squash = 1; enq_val = 1; enq_inst = 32'h0000_0033; enq_pc = 32'h600;
    tick();
    squash = 0; req_fire = 0;
    #1;
    tests++; if (u_p4.drop_cnt_q !== 3'd1) begin fails++; $display("FAIL simul_drop_cnt: got %0d exp 1", u_p4.drop_cnt_q); end
    tests++; if (u_p4.outstanding_q !== 3'd2) begin fails++; $display("FAIL simul_outstanding: got %0d exp 2", u_p4.outstanding_q); end
    enq_pc = 32'h604;
    tick();
    tests++; if (deq_val !== 1'b0) begin fails++; $display("FAIL simul_dropped: got %b exp 0", deq_val); end
    enq_inst = 32'h0000_0037; enq_pc = 32'h608;
    tick();
    enq_val = 0;
    #1;
    tests++; if (deq_val !== 1'b1 || deq_pc !== 32'h608 || deq_imm_type !== 3'd3) begin
      fails++; $display("FAIL simul_new: got val %b pc %h imm %0d exp 1 00000608 3", deq_val, deq_pc, deq_imm_type); end
    deq_rdy = 1;
    tick();
    deq_rdy = 0;
    #1;
    tests++; if (deq_val !== 1'b0) begin fails++; $display("FAIL simul_drain: got %b exp 0", deq_val); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [10];
    logic [2:0]  exp_imm [10];
    tbl = '{32'h0050_0093, 32'h0011_2023, 32'h0020_8463, 32'h0000_0037, 32'h0000_0017,
            32'h0000_006F, 32'h0000_2003, 32'h0000_0067, 32'h0000_0033, 32'h0000_000F};
    exp_imm = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0, 3'd0, 3'd7, 3'd7};
    deq_rdy = 1;
    for (int c = 0; c < 12; c++) begin
      if (c >= 2) begin
        tests++; if (deq_val !== 1'b1 || deq_pc !== 32'h1000 + 32'(4 * (c - 2))) begin
          fails++; $display("FAIL b2b_pc[%0d]: got val %b pc %h exp 1 %h", c - 2, deq_val, deq_pc, 32'h1000 + 32'(4 * (c - 2))); end
        tests++; if (deq_inst !== tbl[c - 2] || deq_imm_type !== exp_imm[c - 2]) begin
          fails++; $display("FAIL b2b_inst[%0d]: got %h imm %0d exp %h imm %0d", c - 2, deq_inst, deq_imm_type, tbl[c - 2], exp_imm[c - 2]); end
      end
      req_fire = (c < 10);
      enq_val  = (c >= 1 && c <= 10);
      if (c >= 1 && c <= 10) begin
        enq_inst = tbl[c - 1];
        enq_pc   = 32'h1000 + 32'(4 * (c - 1));
      end
      tick();
    end
    deq_rdy = 0;
    tests++; if (deq_val !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b exp 0", deq_val); end
  endtask

  task automatic test_reset_midstream();
    req_fire = 1;
    tick();
    enq_val = 1; enq_inst = 32'h0000_0013; enq_pc = 32'h680;
    tick();
    req_fire = 0; enq_val = 0;
    reset_n = 0;
    #1;
    tests++; if (deq_val !== 1'b0 || enq_rdy !== 1'b1 || req_allow !== 1'b1) begin
      fails++; $display("FAIL rst_mid_outputs: got val %b enq_rdy %b allow %b exp 0 1 1", deq_val, enq_rdy, req_allow); end
    tick();
    reset_n = 1;
    tick();
    req_fire = 1;
    tick();
    req_fire = 0; enq_val = 1; enq_inst = 32'h0000_0017; enq_pc = 32'h700;
    tick();
    enq_val = 0;
    #1;
    tests++; if (deq_val !== 1'b1 || deq_pc !== 32'h700 || deq_imm_type !== 3'd3) begin
      fails++; $display("FAIL rst_mid_first: got val %b pc %h imm %0d exp 1 00000700 3", deq_val, deq_pc, deq_imm_type); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_squash_inflight();
    test_simultaneous();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
